// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: memory-stage data-bus controller; issues one aligned request per load/store and stalls until it completes.
module mem_access_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  strobe_type,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        dreq_valid,
  output logic [31:0] dreq_addr,
  output logic [2:0]  dreq_size,
  output logic [3:0]  dreq_strobe,
  output logic [31:0] dreq_data,
  input  logic        addr_ok,
  input  logic        data_ok,
  input  logic [31:0] dresp_data,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata_raw,
  output logic [1:0]  tail,
  output logic [1:0]  out_strobe_type,
  output logic        addr_err
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3;
  logic [1:0]  r_state, w_next;
  logic        r_load;
  logic [1:0]  r_type, r_tail, r_ost;
  logic [31:0] r_addr, r_data, r_rdata;
  logic [2:0]  r_size;
  logic [3:0]  r_strobe, w_strobe;
  logic [31:0] w_data;
  logic [2:0]  w_size;
  logic        w_acc, w_start, w_word, w_half, w_fin;
  assign w_acc    = in_valid & (mem_read | mem_write);
  assign w_word   = strobe_type == 2'b00;
  assign w_half   = strobe_type == 2'b01;
  assign addr_err = w_acc & ((w_word & (addr[1:0] != 2'b00)) | (w_half & addr[0]));
  assign w_start  = w_acc & ~addr_err;
  assign w_strobe = ~mem_write ? 4'h0 : w_word ? 4'hf :
                    w_half ? 4'b0011 << {addr[1], 1'b0} : 4'b0001 << addr[1:0];
  assign w_data   = w_word ? wdata : w_half ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
  assign w_size   = w_word ? 3'd2 : w_half ? 3'd1 : 3'd0;
  // data_ok only counts once the address phase has been accepted
  assign w_fin    = ((r_state == REQ) & addr_ok & data_ok) | ((r_state == WAIT) & data_ok);
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_start ? REQ : IDLE;
      REQ:     w_next = w_fin ? DONE : addr_ok ? WAIT : REQ;
      WAIT:    w_next = w_fin ? DONE : WAIT;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_load   <= 1'b0;
      r_type   <= 2'b00;
      r_addr   <= '0;
      r_data   <= '0;
      r_size   <= '0;
      r_strobe <= '0;
      r_rdata  <= '0;
      r_tail   <= '0;
      r_ost    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_start) begin
        r_load   <= mem_read;
        r_type   <= strobe_type;
        r_addr   <= addr;
        r_data   <= w_data;
        r_size   <= w_size;
        r_strobe <= w_strobe;
      end
      if (w_fin) begin
        if (r_load) r_rdata <= dresp_data;
        r_tail <= r_addr[1:0];
        r_ost  <= r_type;
      end
    end
  end
  assign dreq_valid      = r_state == REQ;
  assign done            = r_state == DONE;
  assign stall           = ((r_state == IDLE) & w_start) | (r_state == REQ) | (r_state == WAIT);
  assign dreq_addr       = r_addr;
  assign dreq_size       = r_size;
  assign dreq_strobe     = r_strobe;
  assign dreq_data       = r_data;
  assign rdata_raw       = r_rdata;
  assign tail            = r_tail;
  assign out_strobe_type = r_ost;
endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory-stage data-bus controller for the MIPS pipeline. It takes a load or store from the execute/memory pipeline register and drives one request on the data bus, aligning the store data and generating the byte strobe. It stalls the pipeline until the bus transaction completes. For loads, it passes the raw 32-bit word, byte offset (`tail`) and access size to the downstream load-extension logic.

## Interface
Parameters: none.

- `clk` input 1 — single clock; all state changes on the rising edge.
- `reset` input 1 — asynchronous, active-high.
- `in_valid` input 1 — the memory-stage instruction is valid.
- `mem_read` input 1 — the instruction is a load.
- `mem_write` input 1 — the instruction is a store. Never high together with `mem_read`.
- `strobe_type` input 2 — access size: 00 word, 01 half, 10 or 11 byte.
- `addr` input 32 — effective address.
- `wdata` input 32 — store data, right-aligned.
- `dreq_valid` output 1 — data-bus request valid.
- `dreq_addr` output 32 — request address.
- `dreq_size` output 3 — 0 byte, 1 half, 2 word.
- `dreq_strobe` output 4 — byte-write enables; 0000 for loads.
- `dreq_data` output 32 — aligned store data.
- `addr_ok` input 1 — the bus accepted the address.
- `data_ok` input 1 — the bus completed the transaction.
- `dresp_data` input 32 — read data, valid when `data_ok` is high.
- `stall` output 1 — hold the pipeline.
- `done` output 1 — one-cycle completion pulse.
- `rdata_raw` output 32 — captured read word.
- `tail` output 2 — `addr[1:0]` of the completed access.
- `out_strobe_type` output 2 — `strobe_type` of the completed access.
- `addr_err` output 1 — misaligned access detected (combinational).

## Operation
- `start` = `in_valid` & (`mem_read` | `mem_write`) & !`addr_err`.
- `addr_err` = `in_valid` & (`mem_read` | `mem_write`) & ((`strobe_type` == 00 & `addr[1:0]` != 0) | (`strobe_type` == 01 & `addr[0]`)).
  - A misaligned access issues no request and raises no stall; the exception path handles it.
- Request fields are registered in IDLE when `start` is high, and held constant until the state returns to IDLE.
- Store alignment, where `t` = `addr[1:0]`:
  - Word: strobe 1111, data = `wdata`.
  - Half: strobe 0011 << {`t[1]`,0}, data = {2{`wdata[15:0]`}}.
  - Byte: strobe 0001 << `t`, data = {4{`wdata[7:0]`}}.
- `dreq_size` is 2, 1 or 0 for word, half or byte.
- `dreq_addr` = `addr` unmodified.
- State machine (states IDLE, REQ, WAIT, DONE):
  - IDLE: if `start` → REQ; otherwise stay.
  - REQ: `dreq_valid` = 1. If `addr_ok` & `data_ok` → DONE, capturing `dresp_data`. If `addr_ok` only → WAIT. Otherwise stay.
  - WAIT: `dreq_valid` = 0. If `data_ok` → DONE, capturing `dresp_data`. Otherwise stay.
  - DONE: `done` = 1 → IDLE unconditionally.
- `stall` = (IDLE & `start`) | REQ | WAIT. It is low in DONE so the pipeline advances on that edge.
- Register updates on entry to DONE:
  - `rdata_raw` is updated only for loads. For stores it holds its previous value.
  - `tail` and `out_strobe_type` are updated for every access.
  - All three hold until the next completion.
- `data_ok` in IDLE or DONE is ignored.
- `data_ok` in REQ without `addr_ok` is ignored.

## Timing
- Reset values:
  - State = IDLE.
  - `dreq_valid`, `done` and `stall` = 0. (`stall` is still driven combinationally by `start`.)
  - `dreq_addr`, `dreq_data`, `rdata_raw` = 0.
  - `dreq_strobe`, `dreq_size`, `tail` = 0.
  - `out_strobe_type` = 00.
- Minimum latency, with `addr_ok` & `data_ok` in the first REQ cycle:
  - Cycle 0: `start`.
  - Cycle 1: REQ.
  - Cycle 2: DONE with `done` = 1 and `rdata_raw` valid.
  - Three cycles in total; `stall` is high for 2 cycles.
- Each extra cycle without `addr_ok` (in REQ) or without `data_ok` (in WAIT) adds one cycle.
- `dreq_valid` stays high from entry to REQ through the `addr_ok` cycle inclusive. Request fields are stable throughout.
- Exactly one `done` pulse per request.
- Back-to-back accesses: a new `start` is taken only in IDLE. A second access therefore reaches REQ no earlier than 2 cycles after DONE.
- Reset in REQ or WAIT: return to IDLE immediately and drop `dreq_valid` asynchronously. Any late `data_ok` after reset is ignored.

## Test plan
- Word load, `addr` = 0x1000_0004, `addr_ok` & `data_ok` in the first REQ cycle with data 0xDEAD_BEEF:
  - `stall` high for 2 cycles.
  - `done` in cycle 2, `rdata_raw` = 0xDEAD_BEEF, `tail` = 0, `out_strobe_type` = 00.
- Byte store, `wdata` = 0x0000_00A5, `addr` = 0x...03:
  - `dreq_strobe` = 1000, `dreq_data` = 0xA5A5_A5A5, `dreq_size` = 0.
  - `rdata_raw` unchanged.
- Half load at 0x...02, `addr_ok` delayed 2 cycles, `data_ok` 3 cycles after `addr_ok`:
  - `dreq_valid` high for exactly 3 cycles.
  - `done` 7 cycles after `start`.
  - `tail` = 10, `out_strobe_type` = 01.
- Misaligned word load at 0x...02:
  - `addr_err` = 1, `dreq_valid` stays 0, `stall` = 0, `done` never pulses.
- Reset asserted in WAIT, then `data_ok` arrives:
  - State IDLE, all outputs at reset values.
  - `done` stays 0.
- Two consecutive half stores (0x...00, then 0x...02):
  - Strobes 0011 then 1100.
  - One `done` per store.
  - Second `dreq_valid` rises no earlier than 2 cycles after the first DONE.
